multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, max consecutive not-ready cycles tolerated in a memory wait state (legal 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  6  instruction bits [31:26] from decoder.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory completes current read/write this cycle.
REQ-007 SHALL have outputs pc_we, ir_we, reg_we, mem_rd, mem_wr, iord, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath strobes/selects.
REQ-008 SHALL have outputs alu_src_b  output  2  (00 reg B, 01 constant 1, 10 sign-ext imm, 11 branch offset); alu_op  output  2  (00 add, 01 sub, 10 funct); pc_src  output  2  (00 ALU result, 01 ALUOut, 10 jump target).
REQ-009 SHALL have outputs instr_done  output  1  one-cycle retire pulse; fault  output  1  sticky error; state  output  4  current state for debug.

Function
REQ-010 SHALL be a Moore-style FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, BEQ, ADDIEXE, ADDIWB, JUMP, FAULT; outputs decode from state, except where gated by mem_ready/zero below; unlisted outputs 0.
REQ-011 FETCH: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_we=pc_we=1 only in cycle mem_ready=1, then DECODE; otherwise hold.
REQ-012 DECODE (1 cycle): alu_src_a=0, alu_src_b=11, alu_op=00; next: 100011/101011 -> MEMADR, 000000 -> RTEXE, 000100 -> BEQ, 001000 -> ADDIEXE, 000010 -> JUMP, any other -> FAULT.
REQ-013 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD for lw, MEMWR for sw.
REQ-014 MEMRD: mem_rd=1, iord=1; on mem_ready -> MEMWB. MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
REQ-015 MEMWR: mem_wr=1, iord=1; on mem_ready: instr_done=1 -> FETCH.
REQ-016 RTEXE: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTWB: reg_we=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
REQ-017 BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=zero, instr_done=1 -> FETCH.
REQ-018 ADDIEXE: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB: reg_we=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
REQ-019 JUMP: pc_src=10, pc_we=1, instr_done=1 -> FETCH.
REQ-020 Latency (zero-wait memory): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles FETCH-entry to FETCH-re-entry.
REQ-021 mem_rd/mem_wr SHALL stay asserted, with iord stable, every cycle of a wait state until mem_ready sampled 1.
REQ-022 8-bit wait counter SHALL increment each wait-state cycle with mem_ready=0 and clear on any state change; reaching TIMEOUT_CYCLES -> FAULT.
REQ-023 mem_ready=1 in the same cycle the timeout would trigger SHALL complete normally (ready wins).
REQ-024 FAULT: all strobes 0, fault=1, instr_done=0; exit only via reset.
REQ-025 state output SHALL equal the state-register encoding each cycle.

Reset
REQ-026 reset sampled high SHALL load state=FETCH, wait counter=0, fault=0.
REQ-027 While reset is high all write/memory strobes (pc_we, ir_we, reg_we, mem_rd, mem_wr) and instr_done SHALL be forced 0.
REQ-028 reset mid-instruction or in FAULT SHALL abandon the instruction; no further strobes for it.

Structure
REQ-029 State encodings, opcode constants, alu_op and alu_src_b/pc_src codes SHALL live in shared package mips_ctrl_pkg, reused by datapath and benches.
REQ-030 The wait counter SHALL be sub-module mem_wait_timer (inputs clk, reset, clear, waiting; output expired).

Verification
REQ-031 Reset then add R-type (opcode 000000), mem_ready tied 1 -> states FETCH,DECODE,RTEXE,RTWB; reg_we=1, reg_dst=1 cycle 4; instr_done one pulse.
REQ-032 lw (100011), mem_ready low 3 cycles during MEMRD -> mem_rd=1, iord=1 held 4 cycles; MEMWB mem_to_reg=1; total 8 cycles.
REQ-033 beq with zero=1 then zero=0 -> pc_we=1, pc_src=01 in BEQ first case; pc_we=0 second.
REQ-034 mem_ready stuck 0 in FETCH, TIMEOUT_CYCLES=4 -> FAULT after 4 wait cycles, fault=1, strobes 0; mem_ready=1 on 4th cycle instead -> DECODE, no fault.
REQ-035 Illegal opcode 111111 -> FAULT after DECODE; reset pulse -> FETCH, fault=0.
REQ-036 reset asserted during MEMWR wait -> next cycle state=FETCH, mem_wr=0, no instr_done.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Used by the controller, the datapath and the benches.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXE   = 4'd6,
        S_RTWB    = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEXE = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_FAULT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // States that hold a memory request open until mem_ready
    function automatic logic is_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait state.
// expired flags the cycle that would be the TIMEOUT_CYCLES-th miss.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= 8'd0;
        else if (waiting)
            count <= count + 8'd1;
    end

    assign expired = waiting && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle MIPS controller with memory wait
// timeout and a sticky fault state left only through reset.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       fault,
    output logic [3:0] state
);

    state_t cur, nxt;
    logic   waiting, expired, done;
    logic   pcw, irw, rgw, mrd, mwr;

    assign waiting = is_wait(cur) && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (nxt != cur),
        .waiting(waiting),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset)
            cur <= S_FETCH;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            S_FETCH:
                if (mem_ready)    nxt = S_DECODE;
                else if (expired) nxt = S_FAULT;
            S_DECODE:
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_RTEXE;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_ADDI:      nxt = S_ADDIEXE;
                    OP_J:         nxt = S_JUMP;
                    default:      nxt = S_FAULT;
                endcase
            S_MEMADR:
                nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:
                if (mem_ready)    nxt = S_MEMWB;
                else if (expired) nxt = S_FAULT;
            S_MEMWR:
                if (mem_ready)    nxt = S_FETCH;
                else if (expired) nxt = S_FAULT;
            S_RTEXE:   nxt = S_RTWB;
            S_ADDIEXE: nxt = S_ADDIWB;
            S_MEMWB, S_RTWB, S_BEQ, S_ADDIWB, S_JUMP:
                nxt = S_FETCH;
            S_FAULT:   nxt = S_FAULT;
            default:   nxt = S_FAULT;
        endcase
    end

    always_comb begin
        pcw        = 1'b0;
        irw        = 1'b0;
        rgw        = 1'b0;
        mrd        = 1'b0;
        mwr        = 1'b0;
        done       = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        unique case (cur)
            S_FETCH: begin
                mrd       = 1'b1;
                alu_src_b = SRCB_ONE;
                pcw       = mem_ready;
                irw       = mem_ready;
            end
            S_DECODE:  alu_src_b = SRCB_BR;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mrd  = 1'b1;
                iord = 1'b1;
            end
            S_MEMWB: begin
                rgw        = 1'b1;
                mem_to_reg = 1'b1;
                done       = 1'b1;
            end
            S_MEMWR: begin
                mwr  = 1'b1;
                iord = 1'b1;
                done = mem_ready;
            end
            S_RTEXE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
                rgw     = 1'b1;
                reg_dst = 1'b1;
                done    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pcw       = zero;
                done      = 1'b1;
            end
            S_ADDIEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                rgw  = 1'b1;
                done = 1'b1;
            end
            S_JUMP: begin
                pc_src = PC_JUMP;
                pcw    = 1'b1;
                done   = 1'b1;
            end
            S_FAULT: ;
            default: ;
        endcase
    end

    // Strobes are masked combinationally so reset kills them at once
    assign pc_we      = pcw  && !reset;
    assign ir_we      = irw  && !reset;
    assign reg_we     = rgw  && !reset;
    assign mem_rd     = mrd  && !reset;
    assign mem_wr     = mwr  && !reset;
    assign instr_done = done && !reset;
    assign fault      = (cur == S_FAULT);
    assign state      = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller.
// Built with TIMEOUT_CYCLES=4 to exercise the wait timeout.
module tb_multicycle_controller;
    import mips_ctrl_pkg::*;

    logic       clk, reset, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_we, ir_we, reg_we, mem_rd, mem_wr, iord;
    logic       reg_dst, mem_to_reg, alu_src_a, instr_done, fault;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];
    int   cmps  = 0;
    int   fails = 0;

    multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we),
        .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
        .fault(fault), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector straight from the per-state output table
    function automatic logic [20:0] model(state_t s, logic rdy,
                                          logic z, logic r);
        logic pw, iw, rw, mr, mw, io, rd, m2r, asa, dn, fl;
        logic [1:0] asb, aop, ps;
        {pw, iw, rw, mr, mw, io, rd, m2r, asa, dn, fl} = '0;
        asb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (s)
            S_FETCH:   begin mr = 1; asb = 2'b01; pw = rdy; iw = rdy; end
            S_DECODE:  asb = 2'b11;
            S_MEMADR:  begin asa = 1; asb = 2'b10; end
            S_MEMRD:   begin mr = 1; io = 1; end
            S_MEMWB:   begin rw = 1; m2r = 1; dn = 1; end
            S_MEMWR:   begin mw = 1; io = 1; dn = rdy; end
            S_RTEXE:   begin asa = 1; aop = 2'b10; end
            S_RTWB:    begin rw = 1; rd = 1; dn = 1; end
            S_BEQ:     begin asa = 1; aop = 2'b01; ps = 2'b01;
                             pw = z; dn = 1; end
            S_ADDIEXE: begin asa = 1; asb = 2'b10; end
            S_ADDIWB:  begin rw = 1; dn = 1; end
            S_JUMP:    begin ps = 2'b10; pw = 1; dn = 1; end
            S_FAULT:   fl = 1;
            default:   ;
        endcase
        if (r) {pw, iw, rw, mr, mw, dn} = '0;
        return {4'(s), pw, iw, rw, mr, mw, io, rd, m2r, asa,
                asb, aop, ps, dn, fl};
    endfunction

    task automatic step(input logic r, input logic [5:0] op,
                        input logic z, input logic rdy,
                        input state_t es, input string tag);
        exp_t e;
        logic [20:0] obs;
        reset = r; opcode = op; zero = z; mem_ready = rdy;
        sb.push_back('{tag, model(es, rdy, z, r)});
        #2;
        e = sb.pop_front();
        obs = {state, pc_we, ir_we, reg_we, mem_rd, mem_wr, iord,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               pc_src, instr_done, fault};
        cmps++;
        assert (obs === e.v) else begin
            fails++;
            $error("FAIL %s: observed %b required %b", e.tag, obs, e.v);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        step(1, OP_RTYPE, 0, 0, S_FETCH, "reset");
        // R-type, zero-wait
        step(0, OP_RTYPE, 0, 1, S_FETCH,  "rt.fetch");
        step(0, OP_RTYPE, 0, 1, S_DECODE, "rt.decode");
        step(0, OP_RTYPE, 0, 1, S_RTEXE,  "rt.exe");
        step(0, OP_RTYPE, 0, 1, S_RTWB,   "rt.wb");
        // lw with three wait cycles in MEMRD
        step(0, OP_LW, 0, 1, S_FETCH,  "lw.fetch");
        step(0, OP_LW, 0, 1, S_DECODE, "lw.decode");
        step(0, OP_LW, 0, 1, S_MEMADR, "lw.memadr");
        for (int i = 0; i < 3; i++)
            step(0, OP_LW, 0, 0, S_MEMRD, "lw.wait");
        step(0, OP_LW, 0, 1, S_MEMRD, "lw.memrd");
        step(0, OP_LW, 0, 1, S_MEMWB, "lw.memwb");
        // sw with two wait cycles
        step(0, OP_SW, 0, 1, S_FETCH,  "sw.fetch");
        step(0, OP_SW, 0, 1, S_DECODE, "sw.decode");
        step(0, OP_SW, 0, 1, S_MEMADR, "sw.memadr");
        step(0, OP_SW, 0, 0, S_MEMWR,  "sw.wait");
        step(0, OP_SW, 0, 0, S_MEMWR,  "sw.wait");
        step(0, OP_SW, 0, 1, S_MEMWR,  "sw.done");
        // addi
        step(0, OP_ADDI, 0, 1, S_FETCH,   "addi.fetch");
        step(0, OP_ADDI, 0, 1, S_DECODE,  "addi.decode");
        step(0, OP_ADDI, 0, 1, S_ADDIEXE, "addi.exe");
        step(0, OP_ADDI, 0, 1, S_ADDIWB,  "addi.wb");
        // beq taken then not taken
        step(0, OP_BEQ, 1, 1, S_FETCH,  "beq1.fetch");
        step(0, OP_BEQ, 1, 1, S_DECODE, "beq1.decode");
        step(0, OP_BEQ, 1, 1, S_BEQ,    "beq1.taken");
        step(0, OP_BEQ, 0, 1, S_FETCH,  "beq0.fetch");
        step(0, OP_BEQ, 0, 1, S_DECODE, "beq0.decode");
        step(0, OP_BEQ, 0, 1, S_BEQ,    "beq0.nottaken");
        // jump
        step(0, OP_J, 0, 1, S_FETCH,  "j.fetch");
        step(0, OP_J, 0, 1, S_DECODE, "j.decode");
        step(0, OP_J, 0, 1, S_JUMP,   "j.jump");
        // ready arrives on the cycle the timeout would fire
        for (int i = 0; i < 3; i++)
            step(0, OP_RTYPE, 0, 0, S_FETCH, "late.wait");
        step(0, OP_RTYPE, 0, 1, S_FETCH,  "late.ready");
        step(0, OP_RTYPE, 0, 1, S_DECODE, "late.decode");
        step(0, OP_RTYPE, 0, 1, S_RTEXE,  "late.exe");
        step(0, OP_RTYPE, 0, 1, S_RTWB,   "late.wb");
        // ready stuck low: timeout into FAULT
        for (int i = 0; i < 4; i++)
            step(0, OP_RTYPE, 0, 0, S_FETCH, "to.wait");
        step(0, OP_RTYPE, 0, 0, S_FAULT, "to.fault");
        step(0, OP_RTYPE, 0, 1, S_FAULT, "to.sticky");
        step(1, OP_RTYPE, 0, 1, S_FAULT, "to.reset");
        // counter restarts from zero after reset
        for (int i = 0; i < 3; i++)
            step(0, OP_J, 0, 0, S_FETCH, "rst.wait");
        step(0, OP_J, 0, 1, S_FETCH,  "rst.ready");
        step(0, OP_J, 0, 1, S_DECODE, "rst.decode");
        step(0, OP_J, 0, 1, S_JUMP,   "rst.jump");
        // illegal opcode
        step(0, 6'b111111, 0, 1, S_FETCH,  "ill.fetch");
        step(0, 6'b111111, 0, 1, S_DECODE, "ill.decode");
        step(0, 6'b111111, 0, 1, S_FAULT,  "ill.fault");
        step(0, 6'b111111, 0, 1, S_FAULT,  "ill.sticky");
        step(1, 6'b111111, 0, 1, S_FAULT,  "ill.reset");
        // reset during sw wait abandons the store
        step(0, OP_SW, 0, 1, S_FETCH,  "swr.fetch");
        step(0, OP_SW, 0, 1, S_DECODE, "swr.decode");
        step(0, OP_SW, 0, 1, S_MEMADR, "swr.memadr");
        step(0, OP_SW, 0, 0, S_MEMWR,  "swr.wait");
        step(1, OP_SW, 0, 1, S_MEMWR,  "swr.reset");
        step(0, OP_SW, 0, 0, S_FETCH,  "swr.after");
        step(0, OP_SW, 0, 1, S_FETCH,  "swr.refetch");
        step(0, OP_SW, 0, 1, S_DECODE, "swr.decode2");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmps, fails);
        $finish;
    end

endmodule
